// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with in-order line refill
// and fence.i flush support.
module icache_dm #(
  parameter int DATA_WIDTH     = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_req,
  input  logic [DATA_WIDTH-1:0] inst_addr,
  output logic                  inst_valid,
  output logic [DATA_WIDTH-1:0] inst_data,
  input  logic                  flush,
  output logic                  mem_req,
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic                  mem_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int OW = $clog2(WORDS_PER_LINE);
  localparam int IW = $clog2(LINES);
  localparam int TW = DATA_WIDTH - IW - OW - 2;

  typedef enum logic [1:0] {
    S_IDLE, S_HIT, S_REFILL, S_RESP
  } state_e;

  state_e                  state_q, state_d;
  logic [LINES-1:0]        valid_q, valid_d;
  logic                    pend_q, pend_d;
  logic [OW-1:0]           k_q, k_d;
  logic                    mreq_q, mreq_d;
  logic [DATA_WIDTH-1:0]   maddr_q, maddr_d;
  logic                    ival_q, ival_d;
  logic [DATA_WIDTH-1:0]   idata_q, idata_d;
  logic                    wr_en, wr_last;

  logic [DATA_WIDTH-1:0]   data_q [LINES][WORDS_PER_LINE];
  logic [TW-1:0]           tag_q  [LINES];

  logic [OW-1:0]           a_off;
  logic [IW-1:0]           a_idx;
  logic [TW-1:0]           a_tag;
  logic [IW-1:0]           r_idx;
  logic [TW-1:0]           r_tag;
  logic                    hit;
  logic                    unused_ok;

  assign a_off = inst_addr[OW+1:2];
  assign a_idx = inst_addr[IW+OW+1:OW+2];
  assign a_tag = inst_addr[DATA_WIDTH-1:IW+OW+2];
  assign unused_ok = ^inst_addr[1:0];

  // refill line identity comes from mem_addr, so it survives a dropped request
  assign r_idx = maddr_q[IW+OW+1:OW+2];
  assign r_tag = maddr_q[DATA_WIDTH-1:IW+OW+2];

  assign hit = !flush && valid_q[a_idx] &&
               (tag_q[a_idx] == a_tag);

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    pend_d  = pend_q;
    k_d     = k_q;
    mreq_d  = mreq_q;
    maddr_d = maddr_q;
    ival_d  = 1'b0;
    idata_d = idata_q;
    wr_en   = 1'b0;
    wr_last = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (flush) valid_d = '0;
        if (inst_req) begin
          if (hit) begin
            state_d = S_HIT;
            ival_d  = 1'b1;
            idata_d = data_q[a_idx][a_off];
          end else begin
            state_d        = S_REFILL;
            k_d            = '0;
            mreq_d         = 1'b1;
            maddr_d        = {inst_addr[DATA_WIDTH-1:OW+2],
                              {(OW+2){1'b0}}};
            valid_d[a_idx] = 1'b0;
          end
        end
      end
      S_HIT: begin
        state_d = S_IDLE;
        if (flush || pend_q) valid_d = '0;
        pend_d = 1'b0;
      end
      S_REFILL: begin
        if (flush) pend_d = 1'b1;
        if (mem_valid) begin
          wr_en = 1'b1;
          if (k_q == OW'(WORDS_PER_LINE - 1)) begin
            wr_last        = 1'b1;
            valid_d[r_idx] = 1'b1;
            mreq_d         = 1'b0;
            state_d        = S_RESP;
          end else begin
            k_d     = k_q + OW'(1);
            maddr_d = maddr_q + DATA_WIDTH'(4);
          end
        end
      end
      S_RESP: begin
        if (flush) pend_d = 1'b1;
        idata_d = data_q[r_idx][a_off];
        ival_d  = inst_req;
        state_d = S_HIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      pend_q  <= 1'b0;
      k_q     <= '0;
      mreq_q  <= 1'b0;
      maddr_q <= '0;
      ival_q  <= 1'b0;
      idata_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
      k_q     <= k_d;
      mreq_q  <= mreq_d;
      maddr_q <= maddr_d;
      ival_q  <= ival_d;
      idata_q <= idata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) data_q[r_idx][k_q] <= mem_rdata;
    if (wr_last) tag_q[r_idx] <= r_tag;
  end

  assign inst_valid = ival_q;
  assign inst_data  = idata_q;
  assign mem_req    = mreq_q;
  assign mem_addr   = maddr_q;

endmodule
